envelope_length_unit: RTL
=========================

Name: envelope_length_unit

Overview:
- Per-channel consumer of the frame sequencer strobes: quarter-frame strobe drives the volume envelope; half-frame strobe drives the length counter.
- Instanced once per pulse/noise channel, between the CPU register-write decode and the channel mixer.
- Produces the 4-bit channel volume, already muted when the length counter has expired.

Parameters:
- LENGTH_WIDTH, 8, width of the length counter and of oLength_count.

Ports:
- iClk  input  1  system clock (1.78 MHz APU clock domain).
- iReset_n  input  1  synchronous, active-low reset.
- iEnvelope_linear_clk  input  1  quarter-frame strobe, 1 cycle wide.
- iLength_sweep_clk  input  1  half-frame strobe, 1 cycle wide.
- iReg0_we  input  1  write strobe, channel control register (offset 0).
- iReg3_we  input  1  write strobe, length-load register (offset 3).
- iData  input  8  CPU write data.
- iChannel_enable  input  1  channel enable bit from the status register.
- oVolume  output  4  channel volume to the mixer.
- oLength_active  output  1  length counter != 0.
- oLength_count  output  LENGTH_WIDTH  current length count.
- oEnvelope_decay  output  4  current envelope decay level.

Behaviour:
- State registers: halt/loop flag H (iData[5]), constant-volume flag C (iData[4]), period/volume V[3:0] (iData[3:0]), start flag S, divider D[3:0], decay E[3:0], length count L.
- Reset: iReset_n sampled low at a rising edge clears all state to 0. Outputs read 0 from the next cycle. Reset mid-operation discards any pending strobe or write in that cycle.
- Outputs decode registered state only, with no combinational path from inputs. An event captured at edge N is visible after edge N.
- oVolume = 0 if L == 0; else V if C = 1; else E.
- oLength_active = (L != 0). oLength_count = L. oEnvelope_decay = E.
- iReg0_we: captures H, C and V at the edge. Strobes in the same cycle use the old H, C and V.
- iReg3_we: sets S = 1.
  - If iChannel_enable = 1, also loads L = LEN_TABLE[iData[7:3]].
- LEN_TABLE, index 0..31: 10,254,20,2,40,4,80,6,160,8,60,10,14,12,26,14,12,16,24,18,48,20,96,22,192,24,72,26,16,28,32,30.
- Envelope step, on iEnvelope_linear_clk = 1:
  - If S (or iReg3_we in the same cycle): S = 0, E = 15, D = V.
  - Else if D == 0: D = V. Then if E != 0, E = E - 1; else if H, E = 15; else E stays 0.
  - Else D = D - 1.
- Length step, on iLength_sweep_clk = 1: if L != 0 and H = 0, L = L - 1. L never wraps below 0.
- Priority for L, highest first:
  - iChannel_enable = 0 forces L = 0 every cycle; iReg3_we loads are ignored.
  - iReg3_we load.
  - Half-frame decrement.
- A load in the same cycle as a half-frame strobe is not decremented.
- iReg3_we in the same cycle as a quarter strobe performs the restart immediately; S ends at 0.
- Both strobes in one cycle: envelope and length steps are independent and both apply.
- The envelope keeps running while L == 0; only oVolume is muted.

Test Plan:
- Reset: run with non-zero state, hold iReset_n = 0 for 1 cycle -> oVolume = 0, oLength_active = 0, oLength_count = 0, oEnvelope_decay = 0 on the next cycle.
- Constant volume and length:
  - iChannel_enable = 1, reg0 = 0x1F, reg3 = 0x08 -> oLength_count = 254, oVolume = 15.
  - 3 half-frame strobes -> oLength_count = 251.
- Envelope decay:
  - reg0 = 0x03, reg3 = 0x00 -> L = 10.
  - Quarter strobe 1 -> E = 15.
  - E decrements on strobes 5, 9, … and reaches 0 at strobe 61, then holds 0.
  - Repeat with reg0 = 0x23 (loop, halt) -> E = 15 again at strobe 65, and L stays 10.
- Disable:
  - L = 254; drop iChannel_enable -> L = 0 and oVolume = 0 the next cycle.
  - reg3 write while disabled -> L stays 0.
- Simultaneous events:
  - reg3 = 0x18 (index 3 -> 2) in the same cycle as a half strobe -> L = 2, not 1.
  - reg3 write in the same cycle as a quarter strobe -> E = 15, S = 0 afterwards.
- Reset mid-decay: iReset_n = 0 in the same cycle as both strobes and a reg3 write -> all state 0; no load and no step applied.

Source files
------------

// File: rtl/envelope_length_unit.sv
// envelope_length_unit
//   Per-channel volume envelope and length counter for a pulse/noise channel.
//   The quarter-frame strobe clocks the envelope divider/decay; the half-frame
//   strobe clocks the length counter. The mixer volume is muted whenever the
//   length counter has expired.
//
// Ports
//   iClk                 APU clock
//   iReset_n             synchronous active-low reset, clears all state
//   iEnvelope_linear_clk quarter-frame strobe (1 cycle)
//   iLength_sweep_clk    half-frame strobe (1 cycle)
//   iReg0_we             control register write (halt/loop, const, volume/period)
//   iReg3_we             length-load register write (restarts envelope)
//   iData                CPU write data
//   iChannel_enable      channel enable from the status register
//   oVolume              4-bit volume to the mixer
//   oLength_active       length counter is non-zero
//   oLength_count        current length count
//   oEnvelope_decay      current envelope decay level
module envelope_length_unit #(
    parameter int LENGTH_WIDTH = 8
) (
    input  logic                    iClk,
    input  logic                    iReset_n,
    input  logic                    iEnvelope_linear_clk,
    input  logic                    iLength_sweep_clk,
    input  logic                    iReg0_we,
    input  logic                    iReg3_we,
    input  logic [7:0]              iData,
    input  logic                    iChannel_enable,
    output logic [3:0]              oVolume,
    output logic                    oLength_active,
    output logic [LENGTH_WIDTH-1:0] oLength_count,
    output logic [3:0]              oEnvelope_decay
);

    logic                    haltFlag,    haltNext;
    logic                    constFlag,   constNext;
    logic [3:0]              volPeriod,   volPeriodNext;
    logic                    startFlag,   startNext;
    logic [3:0]              divider,     dividerNext;
    logic [3:0]              decay,       decayNext;
    logic [LENGTH_WIDTH-1:0] lengthCount, lengthNext;

    function automatic logic [7:0] lenTable(input logic [4:0] idx);
        case (idx)
            5'd0:  lenTable = 8'd10;   5'd1:  lenTable = 8'd254;
            5'd2:  lenTable = 8'd20;   5'd3:  lenTable = 8'd2;
            5'd4:  lenTable = 8'd40;   5'd5:  lenTable = 8'd4;
            5'd6:  lenTable = 8'd80;   5'd7:  lenTable = 8'd6;
            5'd8:  lenTable = 8'd160;  5'd9:  lenTable = 8'd8;
            5'd10: lenTable = 8'd60;   5'd11: lenTable = 8'd10;
            5'd12: lenTable = 8'd14;   5'd13: lenTable = 8'd12;
            5'd14: lenTable = 8'd26;   5'd15: lenTable = 8'd14;
            5'd16: lenTable = 8'd12;   5'd17: lenTable = 8'd16;
            5'd18: lenTable = 8'd24;   5'd19: lenTable = 8'd18;
            5'd20: lenTable = 8'd48;   5'd21: lenTable = 8'd20;
            5'd22: lenTable = 8'd96;   5'd23: lenTable = 8'd22;
            5'd24: lenTable = 8'd192;  5'd25: lenTable = 8'd24;
            5'd26: lenTable = 8'd72;   5'd27: lenTable = 8'd26;
            5'd28: lenTable = 8'd16;   5'd29: lenTable = 8'd28;
            5'd30: lenTable = 8'd32;   default: lenTable = 8'd30;
        endcase
    endfunction

    // Next-state logic. All strobe actions use the register values from before
    // this edge, so a reg0 write coinciding with a strobe takes effect afterwards.
    always_comb begin
        haltNext      = haltFlag;
        constNext     = constFlag;
        volPeriodNext = volPeriod;
        startNext     = startFlag;
        dividerNext   = divider;
        decayNext     = decay;
        lengthNext    = lengthCount;

        if (iReg0_we) begin
            haltNext      = iData[5];
            constNext     = iData[4];
            volPeriodNext = iData[3:0];
        end

        // A reg3 write together with a quarter strobe restarts at once, so
        // the start flag never gets left pending in that case.
        if (iEnvelope_linear_clk) begin
            if (startFlag || iReg3_we) begin
                startNext   = 1'b0;
                decayNext   = 4'd15;
                dividerNext = volPeriod;
            end else if (divider == 4'd0) begin
                dividerNext = volPeriod;
                if (decay != 4'd0) begin
                    decayNext = decay - 4'd1;
                end else if (haltFlag) begin
                    decayNext = 4'd15;
                end
            end else begin
                dividerNext = divider - 4'd1;
            end
        end else if (iReg3_we) begin
            startNext = 1'b1;
        end

        // Disable beats load, load beats decrement.
        if (!iChannel_enable) begin
            lengthNext = '0;
        end else if (iReg3_we) begin
            lengthNext = LENGTH_WIDTH'(lenTable(iData[7:3]));
        end else if (iLength_sweep_clk && (lengthCount != '0) && !haltFlag) begin
            lengthNext = lengthCount - LENGTH_WIDTH'(1);
        end
    end

    always_ff @(posedge iClk) begin
        if (!iReset_n) begin
            haltFlag    <= 1'b0;
            constFlag   <= 1'b0;
            volPeriod   <= 4'd0;
            startFlag   <= 1'b0;
            divider     <= 4'd0;
            decay       <= 4'd0;
            lengthCount <= '0;
        end else begin
            haltFlag    <= haltNext;
            constFlag   <= constNext;
            volPeriod   <= volPeriodNext;
            startFlag   <= startNext;
            divider     <= dividerNext;
            decay       <= decayNext;
            lengthCount <= lengthNext;
        end
    end

    assign oLength_active  = (lengthCount != '0);
    assign oLength_count   = lengthCount;
    assign oEnvelope_decay = decay;
    assign oVolume         = (lengthCount == '0) ? 4'd0 :
                             (constFlag ? volPeriod : decay);

endmodule
